fnd_mode_scheduler: RTL and testbench

//   Sequences the FND data-source mux. Drives the 3-bit mode code that selects which source is shown:

---
 rtl/fnd_mode_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_fnd_mode_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fnd_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fnd_mode_scheduler
// Purpose  : Chooses which data source the FND shows by driving the
//            fndController sw_mode mux code. It has three modes: manual
//            selection, timed auto-rotation over the sources whose data is
//            valid, and a temperature alert that overrides the display and
//            blinks it.
// Ports    : clk        - system clock
//            reset      - asynchronous reset, active low
//            tick_1ms   - 1 ms strobe (one clk wide)
//            auto_en    - 1 = auto-rotation, 0 = manual selection
//            sw_manual  - manual mode code
//            btn_next   - pulse: advance to the next valid source (AUTO only)
//            src_valid  - per-source valid: [0]msec_sec [1]min_hour
//                         [2]distance [3]temp [4]humi
//            temp       - current temperature
//            temp_upd   - pulse: temp holds a new sample
//            sw_mode    - registered mode code to the fndController mux
//            fnd_blank  - registered display blank (alert blink)
//            mode_chg   - registered pulse in the cycle sw_mode changes
// Revision : 1.0 - initial release
// ============================================================================
module fnd_mode_scheduler #(
    parameter int         DWELL_MS   = 3000,
    parameter int         ALERT_MS   = 5000,
    parameter int         BLINK_MS   = 250,
    parameter logic [4:0] TEMP_LIMIT = 5'd30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1ms,
    input  logic       auto_en,
    input  logic [2:0] sw_manual,
    input  logic       btn_next,
    input  logic [4:0] src_valid,
    input  logic [4:0] temp,
    input  logic       temp_upd,
    output logic [2:0] sw_mode,
    output logic       fnd_blank,
    output logic       mode_chg
);

    // A parameter of 1 would give a zero-width counter, so keep at least one bit.
    localparam int DW_W = (DWELL_MS > 1) ? $clog2(DWELL_MS) : 1;
    localparam int AL_W = (ALERT_MS > 1) ? $clog2(ALERT_MS) : 1;
    localparam int BL_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    localparam logic [DW_W-1:0] c_dwell_last = DW_W'(DWELL_MS - 1);
    localparam logic [AL_W-1:0] c_alert_last = AL_W'(ALERT_MS - 1);
    localparam logic [BL_W-1:0] c_blink_last = BL_W'(BLINK_MS - 1);
    localparam logic [2:0]      c_temp_code  = 3'b100;
    localparam logic [2:0]      c_temp_idx   = 3'd3;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_AUTO   = 2'd1,
        ST_ALERT  = 2'd2
    } state_t;

    state_t          r_state, w_state;
    logic [2:0]      r_idx, w_idx;
    logic [2:0]      r_sw_mode, w_sw_mode;
    logic            r_blank, w_blank;
    logic            r_mode_chg;
    logic [DW_W-1:0] r_dwell, w_dwell;
    logic [AL_W-1:0] r_alert, w_alert;
    logic [BL_W-1:0] r_blink, w_blink;

    logic            w_trig;
    logic            w_legal;
    logic [2:0]      w_adv_idx;

    function automatic logic [2:0] f_code(input logic [2:0] idx);
        case (idx)
            3'd1:    return 3'b001;
            3'd2:    return 3'b010;
            3'd3:    return 3'b100;
            3'd4:    return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] f_idx(input logic [2:0] code);
        case (code)
            3'b001:  return 3'd1;
            3'b010:  return 3'd2;
            3'b100:  return 3'd3;
            3'b101:  return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic f_legal(input logic [2:0] code);
        return (code == 3'b000) || (code == 3'b001) || (code == 3'b010) ||
               (code == 3'b100) || (code == 3'b101);
    endfunction

    // First valid source after idx, wrapping mod 5. Scanning from the far end
    // lets the nearest hit overwrite the others; with no hit idx is kept.
    function automatic logic [2:0] f_next(input logic [2:0] idx, input logic [4:0] v);
        logic [2:0] r;
        logic [3:0] s;
        r = idx;
        for (int k = 4; k >= 1; k--) begin
            s = {1'b0, idx} + 4'(k);
            if (s >= 4'd5) s = s - 4'd5;
            if (v[s[2:0]]) r = s[2:0];
        end
        return r;
    endfunction

    assign w_trig    = temp_upd && (temp >= TEMP_LIMIT);
    assign w_legal   = f_legal(sw_manual);
    assign w_adv_idx = f_next(r_idx, src_valid);

    always_comb begin
        w_state   = r_state;
        w_idx     = r_idx;
        w_sw_mode = r_sw_mode;
        w_blank   = r_blank;
        w_dwell   = r_dwell;
        w_alert   = r_alert;
        w_blink   = r_blink;

        if (r_state == ST_ALERT) begin
            // The blink phase runs through retriggers; only the exit forces it off.
            if (tick_1ms) begin
                if (r_blink == c_blink_last) begin
                    w_blink = '0;
                    w_blank = ~r_blank;
                end else begin
                    w_blink = r_blink + 1'b1;
                end
            end
            if (w_trig) begin
                w_alert = '0;
            end else if (tick_1ms) begin
                if (r_alert == c_alert_last) begin
                    w_alert = '0;
                    w_blink = '0;
                    w_blank = 1'b0;
                    w_dwell = '0;
                    if (auto_en) begin
                        w_state = ST_AUTO;
                        w_idx   = c_temp_idx;
                    end else begin
                        w_state   = ST_MANUAL;
                        w_sw_mode = w_legal ? sw_manual : c_temp_code;
                    end
                end else begin
                    w_alert = r_alert + 1'b1;
                end
            end
        end else if (w_trig) begin
            w_state   = ST_ALERT;
            w_idx     = c_temp_idx;
            w_sw_mode = c_temp_code;
            w_blank   = 1'b0;
            w_alert   = '0;
            w_blink   = '0;
        end else if (r_state == ST_MANUAL) begin
            w_dwell = '0;
            if (auto_en) begin
                // Continue rotating from whatever is on screen now.
                w_state = ST_AUTO;
                w_idx   = f_idx(r_sw_mode);
            end else if (w_legal) begin
                w_sw_mode = sw_manual;
            end
        end else begin
            if (!auto_en) begin
                w_state = ST_MANUAL;
                w_dwell = '0;
                if (w_legal) w_sw_mode = sw_manual;
            end else if (btn_next || ((src_valid != 5'd0) && !src_valid[r_idx])) begin
                // A source losing its data is skipped immediately, like a button press.
                w_idx     = w_adv_idx;
                w_sw_mode = f_code(w_adv_idx);
                w_dwell   = '0;
            end else if (tick_1ms) begin
                if (r_dwell == c_dwell_last) begin
                    w_idx     = w_adv_idx;
                    w_sw_mode = f_code(w_adv_idx);
                    w_dwell   = '0;
                end else begin
                    w_dwell = r_dwell + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_MANUAL;
            r_idx      <= 3'd0;
            r_sw_mode  <= 3'b000;
            r_blank    <= 1'b0;
            r_mode_chg <= 1'b0;
            r_dwell    <= '0;
            r_alert    <= '0;
            r_blink    <= '0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_sw_mode  <= w_sw_mode;
            r_blank    <= w_blank;
            r_mode_chg <= (w_sw_mode != r_sw_mode);
            r_dwell    <= w_dwell;
            r_alert    <= w_alert;
            r_blink    <= w_blink;
        end
    end

    assign sw_mode   = r_sw_mode;
    assign fnd_blank = r_blank;
    assign mode_chg  = r_mode_chg;

endmodule
`default_nettype wire

// File: tb/tb_fnd_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fnd_mode_scheduler
// Purpose  : Directed, table-driven self-checking bench for
//            fnd_mode_scheduler (DWELL_MS=4, ALERT_MS=8, BLINK_MS=2,
//            TEMP_LIMIT=30).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fnd_mode_scheduler;

    logic       clk;
    logic       reset;
    logic       tick_1ms;
    logic       auto_en;
    logic [2:0] sw_manual;
    logic       btn_next;
    logic [4:0] src_valid;
    logic [4:0] temp;
    logic       temp_upd;
    logic [2:0] sw_mode;
    logic       fnd_blank;
    logic       mode_chg;

    int n_cmp;
    int n_bad;

    fnd_mode_scheduler #(
        .DWELL_MS   (4),
        .ALERT_MS   (8),
        .BLINK_MS   (2),
        .TEMP_LIMIT (5'd30)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_1ms  (tick_1ms),
        .auto_en   (auto_en),
        .sw_manual (sw_manual),
        .btn_next  (btn_next),
        .src_valid (src_valid),
        .temp      (temp),
        .temp_upd  (temp_upd),
        .sw_mode   (sw_mode),
        .fnd_blank (fnd_blank),
        .mode_chg  (mode_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ae;
        logic [2:0] swm;
        logic       btn;
        logic [4:0] sv;
        logic [4:0] tmp;
        logic       tupd;
        logic       tick;
        logic [2:0] e_sw;
        logic       e_blank;
        logic       e_chg;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic ae, input logic [2:0] swm, input logic btn,
                                input logic [4:0] sv, input logic [4:0] tmp, input logic tupd,
                                input logic tick, input logic [2:0] e_sw, input logic e_blank,
                                input logic e_chg);
        vec_t v;
        v.ae = ae; v.swm = swm; v.btn = btn; v.sv = sv; v.tmp = tmp; v.tupd = tupd;
        v.tick = tick; v.e_sw = e_sw; v.e_blank = e_blank; v.e_chg = e_chg;
        vecs.push_back(v);
    endfunction

    task automatic check3(input string name, input logic [2:0] e_sw, input logic e_blank,
                          input logic e_chg);
        n_cmp++;
        if (sw_mode !== e_sw) begin
            n_bad++;
            $display("FAIL %s sw_mode got %b expected %b", name, sw_mode, e_sw);
        end
        n_cmp++;
        if (fnd_blank !== e_blank) begin
            n_bad++;
            $display("FAIL %s fnd_blank got %b expected %b", name, fnd_blank, e_blank);
        end
        n_cmp++;
        if (mode_chg !== e_chg) begin
            n_bad++;
            $display("FAIL %s mode_chg got %b expected %b", name, mode_chg, e_chg);
        end
    endtask

    localparam logic [4:0] SV = 5'b10101;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0; tick_1ms = 1'b0; auto_en = 1'b0; sw_manual = 3'b000;
        btn_next = 1'b0; src_valid = SV; temp = 5'd20; temp_upd = 1'b0;

        //  ae swm     btn sv        tmp    tu tk  sw      bl ch
        add(0, 3'b000, 0, SV,      5'd20, 0, 0, 3'b000, 0, 0);  // 0  idle MANUAL
        add(0, 3'b101, 0, SV,      5'd20, 0, 0, 3'b101, 0, 1);  // 1  manual select
        add(0, 3'b101, 0, SV,      5'd20, 0, 0, 3'b101, 0, 0);  // 2  pulse drops
        add(0, 3'b111, 0, SV,      5'd20, 0, 0, 3'b101, 0, 0);  // 3  illegal ignored
        add(0, 3'b111, 0, SV,      5'd20, 0, 0, 3'b101, 0, 0);  // 4
        add(0, 3'b000, 0, SV,      5'd20, 0, 0, 3'b000, 0, 1);  // 5
        add(1, 3'b000, 0, SV,      5'd20, 0, 0, 3'b000, 0, 0);  // 6  -> AUTO idx0
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b000, 0, 0);  // 7  tick 1
        add(1, 3'b000, 0, SV,      5'd20, 0, 0, 3'b000, 0, 0);  // 8
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b000, 0, 0);  // 9  tick 2
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b000, 0, 0);  // 10 tick 3
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b010, 0, 1);  // 11 tick 4 -> idx2
        add(1, 3'b000, 0, SV,      5'd20, 0, 0, 3'b010, 0, 0);  // 12
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b010, 0, 0);  // 13 tick 1
        add(1, 3'b000, 1, SV,      5'd20, 0, 0, 3'b101, 0, 1);  // 14 btn -> idx4
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b101, 0, 0);  // 15 tick 1
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b101, 0, 0);  // 16 tick 2
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b101, 0, 0);  // 17 tick 3
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b000, 0, 1);  // 18 tick 4 -> wrap idx0
        add(1, 3'b000, 1, SV,      5'd20, 0, 0, 3'b010, 0, 1);  // 19 btn -> idx2
        add(1, 3'b000, 0, 5'b10001, 5'd20, 0, 0, 3'b101, 0, 1); // 20 distance invalid
        add(1, 3'b000, 0, 5'b00000, 5'd20, 0, 0, 3'b101, 0, 0); // 21 nothing valid: hold
        add(1, 3'b000, 0, 5'b00000, 5'd20, 0, 1, 3'b101, 0, 0); // 22
        add(1, 3'b000, 0, SV,      5'd20, 0, 0, 3'b101, 0, 0);  // 23
        add(1, 3'b000, 1, SV,      5'd30, 1, 0, 3'b100, 0, 1);  // 24 alert beats btn
        add(1, 3'b000, 0, SV,      5'd20, 0, 0, 3'b100, 0, 0);  // 25
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b100, 0, 0);  // 26 a1
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b100, 1, 0);  // 27 a2 blink on
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b100, 1, 0);  // 28 a3
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b100, 0, 0);  // 29 a4
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b100, 0, 0);  // 30 a5
        add(1, 3'b000, 0, SV,      5'd31, 1, 0, 3'b100, 0, 0);  // 31 retrigger
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b100, 1, 0);  // 32 a1, blink phase kept
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b100, 1, 0);  // 33 a2
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b100, 0, 0);  // 34 a3
        add(1, 3'b000, 1, SV,      5'd20, 0, 1, 3'b100, 0, 0);  // 35 a4, btn ignored
        add(0, 3'b001, 0, SV,      5'd20, 0, 1, 3'b100, 1, 0);  // 36 a5, auto_en/sw ignored
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b100, 1, 0);  // 37 a6
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b100, 0, 0);  // 38 a7
        add(1, 3'b000, 0, SV,      5'd20, 0, 1, 3'b100, 0, 0);  // 39 a8 exit -> AUTO idx3
        add(1, 3'b000, 0, SV,      5'd20, 0, 0, 3'b101, 0, 1);  // 40 temp invalid -> idx4
        add(1, 3'b000, 1, SV,      5'd29, 1, 0, 3'b000, 0, 1);  // 41 no alert, btn honoured
        add(0, 3'b010, 0, SV,      5'd20, 0, 0, 3'b010, 0, 1);  // 42 -> MANUAL
        add(0, 3'b010, 0, SV,      5'd20, 0, 0, 3'b010, 0, 0);  // 43
        add(0, 3'b110, 0, SV,      5'd31, 1, 0, 3'b100, 0, 1);  // 44 alert from MANUAL
        add(0, 3'b001, 0, SV,      5'd20, 0, 1, 3'b100, 0, 0);  // 45 a1
        add(0, 3'b001, 0, SV,      5'd20, 0, 1, 3'b100, 1, 0);  // 46 a2
        add(0, 3'b001, 0, SV,      5'd20, 0, 1, 3'b100, 1, 0);  // 47 a3
        add(0, 3'b001, 0, SV,      5'd20, 0, 1, 3'b100, 0, 0);  // 48 a4
        add(0, 3'b001, 0, SV,      5'd20, 0, 1, 3'b100, 0, 0);  // 49 a5
        add(0, 3'b001, 0, SV,      5'd20, 0, 1, 3'b100, 1, 0);  // 50 a6
        add(0, 3'b110, 0, SV,      5'd20, 0, 1, 3'b100, 1, 0);  // 51 a7
        add(0, 3'b110, 0, SV,      5'd20, 0, 1, 3'b100, 0, 0);  // 52 a8 exit, illegal -> 100
        add(0, 3'b001, 0, SV,      5'd20, 0, 0, 3'b001, 0, 1);  // 53 MANUAL again

        // Reset state while reset is held.
        @(posedge clk);
        #1 check3("reset_hold", 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            auto_en   = vecs[i].ae;
            sw_manual = vecs[i].swm;
            btn_next  = vecs[i].btn;
            src_valid = vecs[i].sv;
            temp      = vecs[i].tmp;
            temp_upd  = vecs[i].tupd;
            tick_1ms  = vecs[i].tick;
            @(posedge clk);
            #1 check3($sformatf("vec%0d", i), vecs[i].e_sw, vecs[i].e_blank, vecs[i].e_chg);
        end

        // Asynchronous reset in the middle of AUTO.
        @(negedge clk);
        btn_next = 1'b0; temp_upd = 1'b0; tick_1ms = 1'b0; src_valid = SV;
        auto_en = 1'b1; sw_manual = 3'b001;
        @(posedge clk);                        // enters AUTO at idx1 (invalid source)
        @(posedge clk);                        // skips to idx2
        #1 check3("pre_reset", 3'b010, 1'b0, 1'b1);
        #3 reset = 1'b0;
        #1 check3("async_reset", 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1 check3("reset_held_edge", 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1; auto_en = 1'b0; sw_manual = 3'b101;
        @(posedge clk);
        #1 check3("after_reset_manual", 3'b101, 1'b0, 1'b1);
        @(posedge clk);
        #1 check3("after_reset_hold", 3'b101, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
